// File: rtl/write_sdram_pattern.sv
// write_sdram_pattern
// Avalon-MM burst write master that fills a fixed SDRAM region with a
// beat-indexed pattern: pattern(k) = {~k, k} over the low/high data halves.
// A run is NUM_BURSTS back-to-back bursts of BURST_LEN beats each, starting
// at BASE_ADDR. The read tester downstream checks the same region later.
//
// Ports
//   clk          : single clock (also the slave-port clock)
//   rst          : synchronous, active-high reset
//   start        : one-cycle run request (ignored while busy)
//   address      : burst start word address (held for the whole burst)
//   burstCount   : beats in the current burst
//   waitRequest  : slave stall
//   writeData    : beat data
//   write        : write request
//   byteEnable   : byte lanes, constant all ones
//   busy         : run in progress
//   done         : last run completed, held until next start or reset
//   beatsWritten : accepted beats of the current/last run, saturating

module write_sdram_pattern #(
    parameter int                ADDR_W     = 29,
    parameter int                DATA_W     = 64,
    parameter int                BURST_W    = 8,
    parameter int                BURST_LEN  = 16,
    parameter int                NUM_BURSTS = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 29'h0100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADDR_W-1:0]   address,
    output logic [BURST_W-1:0]  burstCount,
    input  logic                waitRequest,
    output logic [DATA_W-1:0]   writeData,
    output logic                write,
    output logic [DATA_W/8-1:0] byteEnable,
    output logic                busy,
    output logic                done,
    output logic [15:0]         beatsWritten
);

    // state | meaning
    // IDLE  | no run since reset
    // WRITE | presenting beats, write=1
    // DONE  | run finished, done=1 until next start
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int TOTAL  = BURST_LEN * NUM_BURSTS;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int NB_W   = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int HALF_W = DATA_W / 2;

    localparam logic [BURST_W-1:0] BL_CNT      = BURST_W'(BURST_LEN);
    localparam logic [BURST_W-1:0] BL_LAST     = BURST_W'(BURST_LEN - 1);
    localparam logic [NB_W-1:0]    NB_LAST     = NB_W'(NUM_BURSTS - 1);
    localparam logic [ADDR_W-1:0]  ADDR_STRIDE = ADDR_W'(BURST_LEN);

    function automatic logic [DATA_W-1:0] pattern(input logic [CNT_W-1:0] k);
        logic [HALF_W-1:0] h;
        h = HALF_W'(k);
        return {~h, h};
    endfunction

    state_t              state_q,        state_d;
    logic                write_q,        write_d;
    logic [ADDR_W-1:0]   address_q,      address_d;
    logic [BURST_W-1:0]  burst_count_q,  burst_count_d;
    logic [DATA_W-1:0]   data_q,         data_d;
    logic                busy_q,         busy_d;
    logic                done_q,         done_d;
    logic [15:0]         beats_wr_q,     beats_wr_d;
    // Global beat index k, independent of the saturating beatsWritten.
    logic [CNT_W-1:0]    beat_idx_q,     beat_idx_d;
    // Down-counters: beats left in this burst / bursts left after this one.
    logic [BURST_W-1:0]  beats_left_q,   beats_left_d;
    logic [NB_W-1:0]     bursts_left_q,  bursts_left_d;

    logic                accept;
    logic [CNT_W-1:0]    beat_idx_inc;

    assign accept       = write_q && !waitRequest;
    assign beat_idx_inc = beat_idx_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        address_d     = address_q;
        burst_count_d = burst_count_q;
        data_d        = data_q;
        busy_d        = busy_q;
        done_d        = done_q;
        beats_wr_d    = beats_wr_q;
        beat_idx_d    = beat_idx_q;
        beats_left_d  = beats_left_q;
        bursts_left_d = bursts_left_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_WRITE;
                    write_d       = 1'b1;
                    address_d     = BASE_ADDR;
                    burst_count_d = BL_CNT;
                    data_d        = pattern('0);
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    beats_wr_d    = '0;
                    beat_idx_d    = '0;
                    beats_left_d  = BL_LAST;
                    bursts_left_d = NB_LAST;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    beat_idx_d = beat_idx_inc;
                    if (beats_wr_q != 16'hFFFF) begin
                        beats_wr_d = beats_wr_q + 16'd1;
                    end
                    if (beats_left_q != '0) begin
                        beats_left_d = beats_left_q - 1'b1;
                        data_d       = pattern(beat_idx_inc);
                    end else if (bursts_left_q != '0) begin
                        // Next burst follows immediately, no idle cycle.
                        bursts_left_d = bursts_left_q - 1'b1;
                        beats_left_d  = BL_LAST;
                        address_d     = address_q + ADDR_STRIDE;
                        burst_count_d = BL_CNT;
                        data_d        = pattern(beat_idx_inc);
                    end else begin
                        // Address/burstCount/data deliberately retained.
                        state_d = ST_DONE;
                        write_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            address_q     <= '0;
            burst_count_q <= '0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            beats_wr_q    <= '0;
            beat_idx_q    <= '0;
            beats_left_q  <= '0;
            bursts_left_q <= '0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            address_q     <= address_d;
            burst_count_q <= burst_count_d;
            data_q        <= data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            beats_wr_q    <= beats_wr_d;
            beat_idx_q    <= beat_idx_d;
            beats_left_q  <= beats_left_d;
            bursts_left_q <= bursts_left_d;
        end
    end

    assign address      = address_q;
    assign burstCount   = burst_count_q;
    assign writeData    = data_q;
    assign write        = write_q;
    assign byteEnable   = '1;
    assign busy         = busy_q;
    assign done         = done_q;
    assign beatsWritten = beats_wr_q;

endmodule

// File: tb/tb_write_sdram_pattern.sv
// Self-checking bench for write_sdram_pattern. Instance A uses a small
// 4x2 region at 0x100; instance B starts near the top of the address space
// to exercise address wrap between bursts.

module tb_write_sdram_pattern;

    localparam int              AW     = 29;
    localparam int              DW     = 64;
    localparam int              BW     = 8;
    localparam int              BL     = 4;
    localparam int              NB     = 2;
    localparam int              TOTAL  = BL * NB;
    localparam logic [AW-1:0]   BASE_A = 29'h100;
    localparam logic [AW-1:0]   BASE_B = 29'h1FFFFFFE;
    localparam int              LIMIT  = 200;

    logic          clk;
    logic          rst;
    logic          start_a, start_b;
    logic          wait_a, wait_b;

    logic [AW-1:0] address_a, address_b;
    logic [BW-1:0] burst_a, burst_b;
    logic [DW-1:0] data_a, data_b;
    logic          write_a, write_b;
    logic [7:0]    be_a, be_b;
    logic          busy_a, busy_b;
    logic          done_a, done_b;
    logic [15:0]   beats_a, beats_b;

    int n_chk;
    int n_bad;

    write_sdram_pattern #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW),
        .BURST_LEN(BL), .NUM_BURSTS(NB), .BASE_ADDR(BASE_A)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .address(address_a), .burstCount(burst_a), .waitRequest(wait_a),
        .writeData(data_a), .write(write_a), .byteEnable(be_a),
        .busy(busy_a), .done(done_a), .beatsWritten(beats_a)
    );

    write_sdram_pattern #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW),
        .BURST_LEN(BL), .NUM_BURSTS(NB), .BASE_ADDR(BASE_B)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .address(address_b), .burstCount(burst_b), .waitRequest(wait_b),
        .writeData(data_b), .write(write_b), .byteEnable(be_b),
        .busy(busy_b), .done(done_b), .beatsWritten(beats_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference pattern: {~k, k} on 32-bit halves.
    function automatic logic [63:0] pat(input int k);
        logic [31:0] kk;
        kk = k;
        return {~kk, kk};
    endfunction

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_write"}, {63'd0, write_a}, 64'd0);
        chk({tag, "_busy"},  {63'd0, busy_a},  64'd0);
        chk({tag, "_done"},  {63'd0, done_a},  64'd0);
        chk({tag, "_beats"}, {48'd0, beats_a}, 64'd0);
        chk({tag, "_addr"},  {35'd0, address_a}, 64'd0);
        chk({tag, "_bc"},    {56'd0, burst_a}, 64'd0);
        chk({tag, "_data"},  data_a, 64'd0);
    endtask

    // One run on instance A. The model is the accepted-beat count k:
    // while k < TOTAL the presented beat must be beat k of the region.
    // stall_beat/stall_len: hold waitRequest while that beat is presented.
    // start_at: extra start pulse while busy. rst_at: reset while that beat
    // is presented (run abandoned). rand_pct: random stall probability.
    task automatic run_a(input string tag, input int stall_beat, input int stall_len,
                         input int rand_pct, input int start_at, input int rst_at,
                         output int cycles);
        int k;
        int stalled;
        logic w;
        k       = 0;
        stalled = 0;
        cycles  = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        while (k < TOTAL && cycles < LIMIT) begin
            chk({tag, "_write"}, {63'd0, write_a}, 64'd1);
            chk({tag, "_busy"},  {63'd0, busy_a},  64'd1);
            chk({tag, "_done"},  {63'd0, done_a},  64'd0);
            chk({tag, "_addr"},  {35'd0, address_a},
                {35'd0, AW'(BASE_A + AW'((k / BL) * BL))});
            chk({tag, "_bc"},    {56'd0, burst_a}, 64'(BL));
            chk({tag, "_data"},  data_a, pat(k));
            chk({tag, "_beats"}, {48'd0, beats_a}, 64'(k));
            if (k == stall_beat && stalled < stall_len) begin
                w = 1'b1;
                stalled++;
            end else if (rand_pct > 0 && $urandom_range(99) < rand_pct) begin
                w = 1'b1;
            end else begin
                w = 1'b0;
            end
            wait_a  = w;
            start_a = (k == start_at) ? 1'b1 : 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                tick();
                rst     = 1'b0;
                start_a = 1'b0;
                wait_a  = 1'b0;
                chk_reset_a({tag, "_rst"});
                cycles = -1;
                return;
            end
            tick();
            start_a = 1'b0;
            if (!w) k++;
            cycles++;
        end
        wait_a = 1'b0;
        chk({tag, "_bounded"}, 64'(k), 64'(TOTAL));
        chk({tag, "_end_write"}, {63'd0, write_a}, 64'd0);
        chk({tag, "_end_busy"},  {63'd0, busy_a},  64'd0);
        chk({tag, "_end_done"},  {63'd0, done_a},  64'd1);
        chk({tag, "_end_beats"}, {48'd0, beats_a}, 64'(TOTAL));
        chk({tag, "_end_addr"},  {35'd0, address_a},
            {35'd0, AW'(BASE_A + AW'(TOTAL - BL))});
        chk({tag, "_end_data"},  data_a, pat(TOTAL - 1));
        tick();
        chk({tag, "_done_hold"}, {63'd0, done_a}, 64'd1);
        chk({tag, "_idle_wr"},   {63'd0, write_a}, 64'd0);
    endtask

    initial begin
        int cyc;
        int k;
        n_chk   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        wait_a  = 1'b0;
        wait_b  = 1'b0;
        repeat (3) tick();
        // reset and start together: reset wins
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        rst     = 1'b0;
        chk_reset_a("reset");
        chk("reset_be", {56'd0, be_a}, 64'hFF);
        tick();
        chk("idle_stays", {63'd0, write_a}, 64'd0);

        // plain run: 8 beats, done after 8 acceptance edges
        run_a("plain", -1, 0, 0, -1, -1, cyc);
        chk("plain_cycles", 64'(cyc), 64'd8);

        run_a("stall_b2", 2, 3, 0, -1, -1, cyc);
        chk("stall_b2_cycles", 64'(cyc), 64'd11);

        run_a("stall_b4", 4, 5, 0, -1, -1, cyc);
        chk("stall_b4_cycles", 64'(cyc), 64'd13);

        run_a("start_busy", -1, 0, 0, 3, -1, cyc);
        chk("start_busy_cycles", 64'(cyc), 64'd8);

        run_a("rst_mid", -1, 0, 0, -1, 6, cyc);
        tick();
        chk("after_rst_idle", {63'd0, write_a}, 64'd0);
        run_a("restart", -1, 0, 0, -1, -1, cyc);
        chk("restart_cycles", 64'(cyc), 64'd8);

        for (int r = 0; r < 6; r++) begin
            run_a("rand", -1, 0, 40, ((r % 2) == 0) ? int'($urandom_range(TOTAL - 1)) : -1,
                  -1, cyc);
        end

        // address wrap on instance B
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        k = 0;
        while (k < TOTAL) begin
            chk("wrap_write", {63'd0, write_b}, 64'd1);
            chk("wrap_addr",  {35'd0, address_b},
                {35'd0, AW'(BASE_B + AW'((k / BL) * BL))});
            chk("wrap_data",  data_b, pat(k));
            tick();
            k++;
        end
        chk("wrap_done", {63'd0, done_b}, 64'd1);
        chk("wrap_addr_final", {35'd0, address_b}, 64'h2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/write_sdram_pattern.md
Name: write_sdram_pattern

Overview:
- Avalon-MM burst write master for the HPS FPGA-to-SDRAM data port (64-bit, word-addressed).
- Fills a fixed SDRAM region with a deterministic, beat-indexed pattern.
- Sits directly upstream of the SDRAM read tester, which later reads the same region back and checks it.
- Starts on a single `start` pulse and raises `done` when the last beat has been accepted.

Parameters:
- ADDR_W, 29: word-address width. One address unit is one DATA_W word.
- DATA_W, 64: data width in bits. Must be even.
- BURST_W, 8: width of the burstcount signal.
- BURST_LEN, 16: beats per burst. Legal range 1..2^BURST_W-1.
- NUM_BURSTS, 64: number of bursts per run. Must be at least 1.
- BASE_ADDR, 29'h0100000: word address of the first burst.

Ports:
- clk, input, 1: the single clock; also the slave-port clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request to begin a run.
- address, output, ADDR_W: burst start word address.
- burstCount, output, BURST_W: beats in the current burst.
- waitRequest, input, 1: slave stall.
- writeData, output, DATA_W: beat data.
- write, output, 1: write request.
- byteEnable, output, DATA_W/8: byte lanes; all ones.
- busy, output, 1: high while a run is in progress.
- done, output, 1: run completed; holds until the next run starts or reset.
- beatsWritten, output, 16: count of accepted beats in the current or last run; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high (rst).
- Reset values:
  - write=0, address=0, burstCount=0, writeData=0.
  - busy=0, done=0, beatsWritten=0.
  - FSM in IDLE.
  - byteEnable is constant all ones.
- Beat acceptance: a beat is accepted on any rising edge where write=1 and waitRequest=0.
- Stall rule: while write=1 and waitRequest=1, address, burstCount, writeData and write hold their values unchanged.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - start=1 moves to WRITE on the next edge.
  - At the same edge: write=1, address=BASE_ADDR, burstCount=BURST_LEN, writeData=pattern(0), busy=1, done=0, beatsWritten=0.
- WRITE, on each accepted beat:
  - The global beat index k increments; beatsWritten increments.
  - If the beat is not the last in its burst: next writeData=pattern(k+1). address and burstCount stay unchanged.
  - If it is the last beat of a burst but not the last burst: the next burst starts in the very next cycle with no bubble. address += BURST_LEN (wrapping modulo 2^ADDR_W), burstCount=BURST_LEN, writeData=pattern(k+1).
  - If it is the last beat of the last burst: go to DONE. write=0, busy=0, done=1. address, burstCount and writeData are retained.
- Burst-boundary semantics: address and burstCount are meaningful to the slave only on the first beat of a burst. They are still held for the whole burst.
- DONE:
  - done stays at 1.
  - start=1 begins a new run exactly as from IDLE; done clears on that same edge.
- start while busy=1 is ignored. No queuing.
- Pattern: pattern(k) = {~k[DATA_W/2-1:0], k[DATA_W/2-1:0]}, where k is a zero-based beat index across the whole run.
- Run size: total beats = BURST_LEN*NUM_BURSTS. The beat counter is sized to hold this value; it is separate from beatsWritten.
- Minimum run latency: from the start edge to done=1 is BURST_LEN*NUM_BURSTS+1 cycles with waitRequest held at 0.
- rst asserted mid-burst: all outputs return to reset values on that edge.
  - write drops immediately and the burst is abandoned.
  - No completion of the burst is attempted.
- rst and start asserted in the same cycle: rst wins.

Test Plan:
1. Config BURST_LEN=4, NUM_BURSTS=2, BASE_ADDR=0x100; waitRequest=0; pulse start.
   - Required: write=1 for 8 consecutive cycles.
   - Beats 0-3 show address=0x100; beats 4-7 show address=0x104. burstCount=4 throughout.
   - Beat 5 writeData = 64'hFFFFFFFA_00000005.
   - done=1 on the 9th edge after start; beatsWritten=8.
2. Same config; waitRequest=1 for 3 cycles while beat 2 is presented.
   - Required: address, burstCount, writeData (=64'hFFFFFFFD_00000002) and write are stable for those 3 cycles.
   - The run still totals 8 accepted beats; done arrives 3 cycles later than in scenario 1.
3. waitRequest=1 for 5 cycles on the first beat of burst 1 (address=0x104).
   - Required: held values remain 0x104 / 4 / 64'hFFFFFFFB_00000004.
   - No beat is lost or duplicated.
4. Pulse start again at beat 3 while busy=1.
   - Required: no effect; the run completes normally with beatsWritten=8.
5. Assert rst for 1 cycle at beat 6.
   - Required: the next cycle shows write=0, busy=0, done=0, beatsWritten=0.
   - A subsequent start restarts cleanly at address 0x100 with pattern(0)=64'hFFFFFFFF_00000000.
6. After done=1, pulse start with NUM_BURSTS=1 and BASE_ADDR=29'h1FFFFFFE.
   - Required: done clears on the start edge and the burst runs at address 29'h1FFFFFFE.
   - Address-wrap check: compile with NUM_BURSTS=2 and confirm the second burst address = 29'h00000002.
